// File: rtl/mem_access_ctrl_if.sv
// Bundles the pipeline request/response handshake and the data-memory port of mem_access_ctrl.
// The slave modport is the controller's view; master is the pipeline/memory side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: checks alignment and range, extracts/extends loads and performs
// read-modify-write for byte and halfword stores against a word-wide data memory.
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input logic              CLK,
  input logic              RST,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        req_err;
  logic        resp_done;
  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    accept    = (state_q == StIdle) && bus.req_valid;
    resp_done = (state_q == StResp) && bus.resp_ready;
    req_err   = (bus.req_size == 2'b11) ||
                ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)) ||
                (bus.req_addr >= ADDR_LIMIT);
  end

  // Lane extraction for loads and lane merge for sub-word stores share one shift amount.
  always_comb begin
    shamt = {off_q, 3'b000};
    lane  = bus.mem_read_data >> shamt;
    case (size_q)
      2'b00: begin
        load_ext  = unsigned_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        lane_mask = 32'h0000_00ff << shamt;
      end
      2'b01: begin
        load_ext  = unsigned_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        lane_mask = 32'h0000_ffff << shamt;
      end
      default: begin
        load_ext  = bus.mem_read_data;
        lane_mask = 32'hffff_ffff;
      end
    endcase
    merged = (bus.mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_err)                     state_d = StResp;
          else if (!bus.req_write)         state_d = StRead;
          else if (bus.req_size == 2'b10)  state_d = StWrite;
          else                             state_d = StRead;
        end
      end
      StRead:  state_d = write_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == StIdle);
    bus.resp_valid     = (state_q == StResp);
    bus.resp_rdata     = rdata_q;
    bus.resp_error     = err_q;
    bus.mem_read       = (state_q == StRead);
    bus.mem_write      = (state_q == StWrite);
    bus.mem_address    = mem_addr_q;
    bus.mem_write_data = mem_wdata_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q     <= bus.req_write;
        size_q      <= bus.req_size;
        unsigned_q  <= bus.req_unsigned;
        off_q       <= bus.req_addr[1:0];
        wdata_q     <= bus.req_wdata;
        err_q       <= req_err;
        rdata_q     <= 32'h0;
        mem_addr_q  <= req_err ? 32'h0 : {bus.req_addr[31:2], 2'b00};
        mem_wdata_q <= (!req_err && bus.req_write && (bus.req_size == 2'b10)) ?
                       bus.req_wdata : 32'h0;
      end
      if (state_q == StRead) begin
        if (write_q) mem_wdata_q <= merged;
        else         rdata_q     <= load_ext;
      end
      // Memory port returns to zero once the response is consumed.
      if (resp_done) begin
        err_q       <= 1'b0;
        rdata_q     <= 32'h0;
        mem_addr_q  <= 32'h0;
        mem_wdata_q <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small word-addressed memory model.
module tb_mem_access_ctrl;

  logic CLK;
  logic RST;
  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.ADDR_LIMIT(256)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bit [31:0] mem [64];
  bit [31:0] rd_word;
  int        rd_cnt, wr_cnt, overlap_cnt;
  bit [31:0] last_waddr, last_wdata;
  int        checks, errors;
  int        lat, rd0, wr0;

  assign bus.mem_read_data = rd_word;

  always @(posedge bus.mem_read) rd_word = mem[bus.mem_address[7:2]];

  always @(posedge CLK) begin
    if (bus.mem_write) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
      last_waddr <= bus.mem_address;
      last_wdata <= bus.mem_write_data;
      wr_cnt     <= wr_cnt + 1;
    end
    if (bus.mem_read)                  rd_cnt      <= rd_cnt + 1;
    if (bus.mem_read && bus.mem_write) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic complete();
    bus.resp_ready = 1'b1;
    @(posedge CLK); #1;
    bus.resp_ready = 1'b0;
    check("resp_cleared", {31'h0, bus.resp_valid}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'h0, bus.req_ready},  32'h1);
    check({tag, "_resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    check({tag, "_resp_error"}, {31'h0, bus.resp_error}, 32'h0);
    check({tag, "_resp_rdata"}, bus.resp_rdata,          32'h0);
    check({tag, "_mem_read"},   {31'h0, bus.mem_read},   32'h0);
    check({tag, "_mem_write"},  {31'h0, bus.mem_write},  32'h0);
    check({tag, "_mem_addr"},   bus.mem_address,         32'h0);
    check({tag, "_mem_wdata"},  bus.mem_write_data,      32'h0);
  endtask

  logic [1:0]  err_size [4];
  logic        err_wr   [4];
  logic [31:0] err_addr [4];

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    // sw / lw round trip
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", {31'h0, bus.resp_error}, 32'h0);
    check("sw_rdata", bus.resp_rdata, 32'h0);
    check("sw_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    check("sw_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
    check("sw_waddr", last_waddr, 32'h10);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    complete();

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", bus.resp_rdata, 32'hDEADBEEF);
    check("lw_err", {31'h0, bus.resp_error}, 32'h0);
    check("lw_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("lw_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
    complete();

    // byte store read-modify-write and byte loads
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    complete();
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("sb_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    check("sb_waddr", last_waddr, 32'h20);
    check("sb_wdata", last_wdata, 32'h1122AA44);
    complete();
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    check("lbu_rdata", bus.resp_rdata, 32'h000000AA);
    complete();
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    check("lb_rdata", bus.resp_rdata, 32'hFFFFFFAA);
    complete();

    // halfword loads
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h8001FFFF);
    complete();
    issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("lh_rdata", bus.resp_rdata, 32'hFFFF8001);
    complete();
    issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
    check("lhu_rdata", bus.resp_rdata, 32'h0000FFFF);
    complete();

    // error cases: misaligned lw, misaligned sh, out of range, reserved size
    err_wr[0] = 1'b0; err_size[0] = 2'b10; err_addr[0] = 32'h22;
    err_wr[1] = 1'b1; err_size[1] = 2'b01; err_addr[1] = 32'h13;
    err_wr[2] = 1'b0; err_size[2] = 2'b10; err_addr[2] = 32'h100;
    err_wr[3] = 1'b0; err_size[3] = 2'b11; err_addr[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      issue(err_wr[i], err_size[i], 1'b0, err_addr[i], 32'h12345678);
      check($sformatf("err%0d_lat", i), 32'(lat), 32'd1);
      check($sformatf("err%0d_flag", i), {31'h0, bus.resp_error}, 32'h1);
      check($sformatf("err%0d_rdata", i), bus.resp_rdata, 32'h0);
      check($sformatf("err%0d_strobes", i), 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
      complete();
    end

    // response backpressure
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), {31'h0, bus.resp_valid}, 32'h1);
      check($sformatf("hold%0d_rdata", i), bus.resp_rdata, 32'h1122AA44);
      check($sformatf("hold%0d_ready", i), {31'h0, bus.req_ready}, 32'h0);
      @(posedge CLK); #1;
    end
    complete();
    check("hold_req_ready", {31'h0, bus.req_ready}, 32'h1);

    // reset during the read phase of a byte store
    wr0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 32'h10;
    bus.req_wdata = 32'h00000055;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    check("abort_in_read", {31'h0, bus.mem_read}, 32'h1);
    RST = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("abort_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
    check("abort_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("abort_lw_rdata", bus.resp_rdata, 32'hDEADBEEF);
    complete();

    check("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
